// File: rtl/axis_pixel_packer.sv
// Packs R = OUT_WIDTH/IN_WIDTH pixel beats per output word, with a one-word skid buffer.
// Define AXIS_PIXEL_PACKER_LANESWAP_EN to fill lanes from the top (beat 0 in lane R-1).
module axis_pixel_packer #(
  parameter int IN_WIDTH   = 16,
  parameter int OUT_WIDTH  = 32,
  parameter int STRB_WIDTH = OUT_WIDTH/8
) (
  input  logic                  aclk,
  input  logic                  resetn,
  input  logic [IN_WIDTH-1:0]   s_xdata,
  input  logic                  s_xvalid,
  input  logic                  s_xlast,
  output logic                  s_xready,
  output logic [OUT_WIDTH-1:0]  m_xdata,
  output logic [STRB_WIDTH-1:0] m_xstrb,
  output logic                  m_xlast,
  output logic                  m_xvalid,
  input  logic                  m_xready,
  output logic [31:0]           wordCount
);
  localparam int R   = OUT_WIDTH/IN_WIDTH;
  localparam int LW  = $clog2(R);
  localparam int BPL = IN_WIDTH/8;

  typedef struct packed {
    logic [OUT_WIDTH-1:0]  data;
    logic [STRB_WIDTH-1:0] strb;
    logic                  last;
  } word_t;

  logic [LW-1:0] lane_q, lane_d, pos;
  word_t         pack_q, pack_d, new_w, out_q, out_d, skd_q, skd_d;
  logic          out_vld_q, out_vld_d, skd_vld_q, skd_vld_d;
  logic          rdy_q;
  logic [31:0]   cnt_q;
  logic          s_fire, m_fire, done;

  // rdy_q keeps s_xready low during reset and rises on the first clock after release
  assign s_xready  = rdy_q & ~skd_vld_q;
  assign s_fire    = s_xvalid & s_xready;
  assign m_fire    = out_vld_q & m_xready;
  assign done      = s_fire & (s_xlast | (lane_q == LW'(R-1)));

  assign m_xdata   = out_q.data;
  assign m_xstrb   = out_q.strb;
  assign m_xlast   = out_q.last;
  assign m_xvalid  = out_vld_q;
  assign wordCount = cnt_q;

`ifdef AXIS_PIXEL_PACKER_LANESWAP_EN
  assign pos = LW'(R-1) - lane_q;
`else
  assign pos = lane_q;
`endif

  // Partial word merged with the current beat; unfilled lanes stay zero
  always_comb begin
    new_w      = pack_q;
    new_w.last = s_xlast;
    for (int k = 0; k < R; k++) begin
      if (pos == LW'(k)) begin
        new_w.data[k*IN_WIDTH +: IN_WIDTH] = s_xdata;
        new_w.strb[k*BPL +: BPL]           = '1;
      end
    end
  end

  always_comb begin
    lane_d    = lane_q;
    pack_d    = pack_q;
    out_d     = out_q;
    out_vld_d = out_vld_q;
    skd_d     = skd_q;
    skd_vld_d = skd_vld_q;
    if (s_fire) begin
      if (done) begin
        lane_d = '0;
        pack_d = '0;
      end else begin
        lane_d = lane_q + LW'(1);
        pack_d = new_w;
      end
    end
    // A full skid blocks input, so done cannot coincide with skd_vld_q
    if (m_fire || !out_vld_q) begin
      if (skd_vld_q) begin
        out_d     = skd_q;
        out_vld_d = 1'b1;
        skd_vld_d = 1'b0;
      end else if (done) begin
        out_d     = new_w;
        out_vld_d = 1'b1;
      end else begin
        out_vld_d = 1'b0;
      end
    end else if (done) begin
      skd_d     = new_w;
      skd_vld_d = 1'b1;
    end
  end

  always_ff @(posedge aclk or negedge resetn) begin
    if (!resetn) begin
      lane_q    <= '0;
      pack_q    <= '0;
      out_q     <= '0;
      out_vld_q <= 1'b0;
      skd_q     <= '0;
      skd_vld_q <= 1'b0;
      rdy_q     <= 1'b0;
      cnt_q     <= '0;
    end else begin
      lane_q    <= lane_d;
      pack_q    <= pack_d;
      out_q     <= out_d;
      out_vld_q <= out_vld_d;
      skd_q     <= skd_d;
      skd_vld_q <= skd_vld_d;
      rdy_q     <= 1'b1;
      if (m_fire) cnt_q <= cnt_q + 32'd1;
    end
  end
endmodule
